// File: rtl/seq_div.sv
// seq_div: iterative unsigned restoring divider, one quotient bit per cycle.
// A go_T pulse accepted while idle yields quot/rem with a one-cycle done
// pulse WIDTH+1 cycles later. A go_T on the done cycle is accepted.
// Optional feature macro: SEQ_DIV_ZERO_FLAG_EN adds the registered div_zero
// output, which flags results produced with a zero divisor.
module seq_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_T,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after WIDTH steps this register holds the quotient.
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_shf;

`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic dzp_q, dzp_d;
    logic dz_q, dz_d;
`endif

    // One restoring step: WIDTH+1-bit trial compare, subtract when it fits.
    // The difference is below the divisor, so WIDTH bits suffice for it.
    always_comb begin
        trial    = {prem_q, shf_q[WIDTH-1]};
        ge       = (trial >= {1'b0, dvs_q});
        step_rem = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
        step_shf = {shf_q[WIDTH-2:0], ge};
    end

    // Next-state logic for the IDLE/BUSY controller and datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shf_d   = shf_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
        dzp_d   = dzp_q;
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (go_T) begin
                    shf_d   = left;
                    dvs_d   = right;
                    prem_d  = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = BUSY;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                    dzp_d   = (right == '0);
`endif
                end
            end
            BUSY: begin
                prem_d = step_rem;
                shf_d  = step_shf;
                if (cnt_q == '0) begin
                    quot_d  = step_shf;
                    rem_d   = step_rem;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                    dz_d    = dzp_q;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shf_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shf_q   <= shf_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

`ifdef SEQ_DIV_ZERO_FLAG_EN
    // Zero-divisor flag: captured at acceptance, published at completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dzp_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            dzp_q <= dzp_d;
            dz_q  <= dz_d;
        end
    end

    assign div_zero = dz_q;
`endif

    assign quot = quot_q;
    assign rem  = rem_q;
    assign done = done_q;

endmodule
